odu_gen_sched: RTL and testbench

ODU_GEN_SCHED -- requirements
Module: odu_gen_sched

---
 rtl/odu_gen_pkg.sv | 27 ++
 rtl/odu_rr_pick.sv | 42 ++++
 rtl/odu_gen_sched.sv | 170 +++++++++++++++++
 tb/tb_odu_gen_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odu_gen_pkg.sv
// Shared types, widths and the payload-word formatter for the ODU generator scheduler.
package odu_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int   CHID_W     = 7;
  localparam int   DATA_OUT_W = 32;
  localparam logic TYPE_INC   = 1'b0;
  localparam logic TYPE_INV   = 1'b1;

  // Type 1 payloads are the bitwise inverse of the incrementing pattern.
  function automatic logic [DATA_OUT_W-1:0] make_word(
    input logic [CHID_W-1:0] chid,
    input logic [7:0]        seq,
    input logic [15:0]       idx,
    input logic              ptype
  );
    logic [DATA_OUT_W-1:0] w;
    w = {1'b0, chid, seq, idx};
    return (ptype == TYPE_INV) ? ~w : w;
  endfunction

endpackage

// File: rtl/odu_rr_pick.sv
// Combinational round-robin picker: lowest requesting index strictly after 'last', wrapping to 0.
module odu_rr_pick
  import odu_gen_pkg::*;
#(
  parameter int NUM_CH = 80
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHID_W-1:0] last,
  output logic              found,
  output logic [CHID_W-1:0] index
);

  logic              hi_found;
  logic              lo_found;
  logic [CHID_W-1:0] hi_idx;
  logic [CHID_W-1:0] lo_idx;

  // Descending scan so the lowest match in each half (above / at-or-below last) wins.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = {CHID_W{1'b0}};
    lo_idx   = {CHID_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hi_found = (req[i] && (CHID_W'(i) > last))  ? 1'b1        : hi_found;
      hi_idx   = (req[i] && (CHID_W'(i) > last))  ? CHID_W'(i)  : hi_idx;
      lo_found = (req[i] && (CHID_W'(i) <= last)) ? 1'b1        : lo_found;
      lo_idx   = (req[i] && (CHID_W'(i) <= last)) ? CHID_W'(i)  : lo_idx;
    end
    if (hi_found) begin
      found = 1'b1;
      index = hi_idx;
    end else if (lo_found) begin
      found = 1'b1;
      index = lo_idx;
    end else begin
      found = 1'b0;
      index = {CHID_W{1'b0}};
    end
  end

endmodule

// File: rtl/odu_gen_sched.sv
// ODU test-frame generator: round-robins over enabled channels and emits FRAME_LEN-word
// frames with a per-channel sequence number, under valid/ready flow control.
module odu_gen_sched
  import odu_gen_pkg::*;
#(
  parameter int NUM_CH         = 80,
  parameter int FRAME_LEN      = 16,
  parameter int DATA_WIDTH_CFG = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_start_reg,
  input  logic [NUM_CH-1:0]         cfg_enable_chid,
  input  logic [NUM_CH-1:0]         cfg_type_chid,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_OUT_W-1:0]     o_data,
  output logic [CHID_W-1:0]         o_chid,
  output logic                      o_sof,
  output logic                      o_eof,
  output logic                      status_gen_data
);

  localparam logic [15:0]       LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [CHID_W-1:0] LAST_CH  = CHID_W'(NUM_CH - 1);

  state_t            state;
  state_t            state_nx;
  logic [15:0]       idx;
  logic [15:0]       idx_nx;
  logic [15:0]       idx_inc;
  logic [CHID_W-1:0] chid_nx;
  logic              frame_type;
  logic              frame_type_nx;
  logic [CHID_W-1:0] last_chid;
  logic [CHID_W-1:0] last_chid_nx;
  logic              valid_nx;
  logic [DATA_OUT_W-1:0] data_nx;
  logic              sof_nx;
  logic              eof_nx;
  logic              status_nx;
  logic              seq_inc;
  logic              run;
  logic              accept;
  logic              pick_found;
  logic [CHID_W-1:0] pick_idx;
  logic [7:0]        seq [NUM_CH];
  logic              unused_cfg;

  assign run        = cfg_start_reg[0];
  assign unused_cfg = ^cfg_start_reg[DATA_WIDTH_CFG-1:1];
  assign accept     = o_valid & i_ready;
  assign idx_inc    = idx + 16'd1;

  odu_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .req   (cfg_enable_chid),
    .last  (last_chid),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next-state and next-output computation; output registers load these values.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    chid_nx       = o_chid;
    frame_type_nx = frame_type;
    last_chid_nx  = last_chid;
    valid_nx      = o_valid;
    data_nx       = o_data;
    sof_nx        = o_sof;
    eof_nx        = o_eof;
    seq_inc       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nx = ST_SCAN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!run) begin
          state_nx = ST_IDLE;
        end else if (pick_found) begin
          state_nx      = ST_SEND;
          chid_nx       = pick_idx;
          frame_type_nx = cfg_type_chid[pick_idx];
          idx_nx        = 16'd0;
          valid_nx      = 1'b1;
          data_nx       = make_word(pick_idx, seq[pick_idx], 16'd0, cfg_type_chid[pick_idx]);
          sof_nx        = 1'b1;
          eof_nx        = (LAST_IDX == 16'd0);
        end else begin
          state_nx = ST_SCAN;
        end
      end
      ST_SEND: begin
        if (accept && (idx == LAST_IDX)) begin
          // Last word taken: close the frame and leave a one-cycle gap.
          seq_inc      = 1'b1;
          last_chid_nx = o_chid;
          idx_nx       = 16'd0;
          valid_nx     = 1'b0;
          data_nx      = {DATA_OUT_W{1'b0}};
          sof_nx       = 1'b0;
          eof_nx       = 1'b0;
          state_nx     = run ? ST_SCAN : ST_IDLE;
        end else if (accept) begin
          idx_nx  = idx_inc;
          data_nx = make_word(o_chid, seq[o_chid], idx_inc, frame_type);
          sof_nx  = 1'b0;
          eof_nx  = (idx_inc == LAST_IDX);
        end else begin
          state_nx = ST_SEND;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        valid_nx = 1'b0;
        data_nx  = {DATA_OUT_W{1'b0}};
        sof_nx   = 1'b0;
        eof_nx   = 1'b0;
        idx_nx   = 16'd0;
      end
    endcase
    status_nx = (state_nx != ST_IDLE);
  end

  // State, frame context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      idx             <= 16'd0;
      o_chid          <= {CHID_W{1'b0}};
      frame_type      <= TYPE_INC;
      last_chid       <= LAST_CH;
      o_valid         <= 1'b0;
      o_data          <= {DATA_OUT_W{1'b0}};
      o_sof           <= 1'b0;
      o_eof           <= 1'b0;
      status_gen_data <= 1'b0;
    end else begin
      state           <= state_nx;
      idx             <= idx_nx;
      o_chid          <= chid_nx;
      frame_type      <= frame_type_nx;
      last_chid       <= last_chid_nx;
      o_valid         <= valid_nx;
      o_data          <= data_nx;
      o_sof           <= sof_nx;
      o_eof           <= eof_nx;
      status_gen_data <= status_nx;
    end
  end

  // Per-channel frame counters, advanced when a frame's last word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_CH; n++) begin
        seq[n] <= 8'd0;
      end
    end else if (seq_inc) begin
      seq[o_chid] <= seq[o_chid] + 8'd1;
    end
  end

endmodule

// File: tb/tb_odu_gen_sched.sv
// Self-checking bench for odu_gen_sched: a frame-level behavioural model checked every cycle,
// directed scenarios with hand-computed words, then randomized traffic.
module tb_odu_gen_sched;

  localparam int NUM_CH    = 80;
  localparam int FRAME_LEN = 16;
  localparam int DW        = 16;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     cfg_start_reg;
  logic [NUM_CH-1:0] cfg_enable_chid;
  logic [NUM_CH-1:0] cfg_type_chid;
  logic              o_valid;
  logic              i_ready;
  logic [31:0]       o_data;
  logic [6:0]        o_chid;
  logic              o_sof;
  logic              o_eof;
  logic              status_gen_data;

  int errors = 0;
  int checks = 0;

  odu_gen_sched #(
    .NUM_CH         (NUM_CH),
    .FRAME_LEN      (FRAME_LEN),
    .DATA_WIDTH_CFG (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start_reg   (cfg_start_reg),
    .cfg_enable_chid (cfg_enable_chid),
    .cfg_type_chid   (cfg_type_chid),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_data          (o_data),
    .o_chid          (o_chid),
    .o_sof           (o_sof),
    .o_eof           (o_eof),
    .status_gen_data (status_gen_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 looking for a channel, 2 sending word m_cnt of channel m_ch.
  int m_mode;
  int m_ch;
  int m_cnt;
  int m_last;
  bit m_typ;
  int m_seq [NUM_CH];

  function automatic logic [31:0] exp_word(input int ch, input int sq, input int cnt, input bit t);
    logic [31:0] w;
    w = {ch[7:0], sq[7:0], cnt[15:0]};
    return t ? ~w : w;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ch   = 0;
    m_cnt  = 0;
    m_last = NUM_CH - 1;
    m_typ  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_seq[i] = 0;
  endtask

  task automatic model_step();
    bit run;
    run = cfg_start_reg[0];
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (run) m_mode = 1;
        1: begin
          if (!run) begin
            m_mode = 0;
          end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
              int c;
              c = (m_last + k) % NUM_CH;
              if (cfg_enable_chid[c]) begin
                m_ch   = c;
                m_typ  = cfg_type_chid[c];
                m_cnt  = 0;
                m_mode = 2;
                break;
              end
            end
          end
        end
        default: begin
          if (i_ready) begin
            if (m_cnt == FRAME_LEN - 1) begin
              m_seq[m_ch] = (m_seq[m_ch] + 1) % 256;
              m_last      = m_ch;
              m_mode      = run ? 1 : 0;
            end else begin
              m_cnt++;
            end
          end
        end
      endcase
    end
  endtask

  initial model_reset();

  // Advance the model on each edge, then compare the DUT just after the edge.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("valid", 32'(o_valid), 32'(m_mode == 2));
    chk("sof", 32'(o_sof), 32'(m_mode == 2 && m_cnt == 0));
    chk("eof", 32'(o_eof), 32'(m_mode == 2 && m_cnt == FRAME_LEN - 1));
    chk("status", 32'(status_gen_data), 32'(m_mode != 0));
    if (m_mode == 2) begin
      chk("data", o_data, exp_word(m_ch, m_seq[m_ch], m_cnt, m_typ));
      chk("chid", 32'(o_chid), 32'(m_ch));
    end
  end

  task automatic wait_sof(output logic [31:0] d, output logic [6:0] c);
    bit seen;
    seen = 1'b0;
    d = 32'd0;
    c = 7'd0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (o_valid && o_sof) begin
        seen = 1'b1;
        d = o_data;
        c = o_chid;
      end
    end
    if (!seen) chk("sof_timeout", 32'(o_valid && o_sof), 32'd1);
  endtask

  task automatic wait_eof();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (o_valid && o_eof) seen = 1'b1;
    end
    if (!seen) chk("eof_timeout", 32'(o_valid && o_eof), 32'd1);
  endtask

  task automatic wait_idx(input int want);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (o_valid && (o_data[15:0] == want[15:0])) seen = 1'b1;
    end
    if (!seen) chk("idx_timeout", 32'(o_data[15:0]), 32'(want));
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (!status_gen_data) seen = 1'b1;
    end
    chk("idle_reached", 32'(status_gen_data), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [6:0]  c;
    int acc, sofs, eofs, lat;
    bit prev_stall;
    logic [31:0] prev_data;
    bit pat [4];

    rst_n           = 1'b0;
    i_ready         = 1'b1;
    cfg_start_reg   = 16'd0;
    cfg_enable_chid = '0;
    cfg_type_chid   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_chid", 32'(o_chid), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_eof", 32'(o_eof), 32'd0);
    chk("rst_status", 32'(status_gen_data), 32'd0);

    // Round-robin over channels 0, 5, 79 with sequence rollover on channel 0.
    cfg_enable_chid[0]  = 1'b1;
    cfg_enable_chid[5]  = 1'b1;
    cfg_enable_chid[79] = 1'b1;
    cfg_start_reg       = 16'd1;
    wait_sof(d, c); chk("rr1_chid", 32'(c), 32'd0);  chk("rr1_data", d, 32'h0000_0000);
    wait_sof(d, c); chk("rr2_chid", 32'(c), 32'd5);  chk("rr2_data", d, 32'h0500_0000);
    wait_sof(d, c); chk("rr3_chid", 32'(c), 32'd79); chk("rr3_data", d, 32'h4F00_0000);
    wait_sof(d, c); chk("rr4_chid", 32'(c), 32'd0);  chk("rr4_data", d, 32'h0001_0000);
    cfg_start_reg = 16'd0;
    wait_idle();

    // Inverted payload type on channel 3.
    cfg_enable_chid    = '0;
    cfg_enable_chid[3] = 1'b1;
    cfg_type_chid[3]   = 1'b1;
    cfg_start_reg      = 16'd1;
    wait_sof(d, c); chk("inv_chid", 32'(c), 32'd3); chk("inv_sof_data", d, 32'hFCFF_FFFF);
    wait_eof();     chk("inv_eof_data", o_data, 32'hFCFF_FFF0);

    // Back-pressure pattern 1,0,0,1 over the next channel-3 frame.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    acc = 0; sofs = 0; eofs = 0;
    prev_stall = 1'b0;
    prev_data  = 32'd0;
    for (int n = 0; n < 300 && eofs == 0; n++) begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold", o_data, prev_data);
      i_ready = pat[n % 4];
      if (o_valid && i_ready) begin
        acc++;
        if (o_sof) sofs++;
        if (o_eof) eofs++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
    chk("stall_words", 32'(acc), 32'd16);
    chk("stall_sofs", 32'(sofs), 32'd1);
    chk("stall_eofs", 32'(eofs), 32'd1);
    @(negedge clk);
    i_ready         = 1'b1;
    cfg_enable_chid = '0;
    cfg_type_chid   = '0;

    // Running with nothing enabled, then enabling channel 10.
    repeat (3) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("noen_valid", 32'(o_valid), 32'd0);
      chk("noen_status", 32'(status_gen_data), 32'd1);
    end
    cfg_enable_chid[10] = 1'b1;
    lat = 0;
    for (int n = 0; n < 10 && !o_valid; n++) begin
      @(negedge clk);
      lat++;
    end
    chk("en10_latency_ok", 32'(lat >= 1 && lat <= 2), 32'd1);
    chk("en10_chid", 32'(o_chid), 32'd10);
    chk("en10_data", o_data, 32'h0A00_0000);

    // Stop mid-frame, frame still completes, restart resumes round-robin.
    cfg_enable_chid[20] = 1'b1;
    wait_idx(4);
    cfg_start_reg = 16'd0;
    wait_eof();
    chk("stop_eof_chid", 32'(o_chid), 32'd10);
    wait_idle();
    cfg_start_reg = 16'd1;
    wait_sof(d, c); chk("restart_chid", 32'(c), 32'd20); chk("restart_data", d, 32'h1400_0000);
    wait_sof(d, c); chk("seq_keep_chid", 32'(c), 32'd10); chk("seq_keep_data", d, 32'h0A01_0000);

    // Asynchronous reset in the middle of a frame.
    cfg_enable_chid[0] = 1'b1;
    wait_idx(7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_data", o_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sof(d, c); chk("post_rst_chid", 32'(c), 32'd0); chk("post_rst_data", d, 32'h0000_0000);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      i_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 63) == 0) begin
        for (int b = 0; b < NUM_CH; b++) begin
          cfg_enable_chid[b] = ($urandom_range(0, 15) == 0);
          cfg_type_chid[b]   = ($urandom_range(0, 1) == 1);
        end
      end
      if ($urandom_range(0, 299) == 0) cfg_start_reg[0] = ~cfg_start_reg[0];
    end
    i_ready       = 1'b1;
    cfg_start_reg = 16'd0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
